bin2bcd_seq: RTL

- Sequential binary-to-BCD converter using shift-add-3 (double dabble).
- Sits directly downstream of the 32-bit sequential divider.
- Consumes the divider's quotient (or zero-extended remainder) and produces packed decimal digits for display and monitor logic.
- One bit per clock, in a start/busy/done handshake that matches the divider's fixed-latency operation.

---
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (shift-add-3 / double dabble).
// Converts one input bit per clock. A conversion takes WIDTH cycles from the
// accepted start edge to the done pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   r      in   asynchronous active-high reset
//   start  in   conversion request, accepted only while idle
//   bin    in   [WIDTH-1:0] unsigned value, captured on an accepted start
//   busy   out  high while a conversion is running
//   done   out  one-cycle pulse when bcd has just been updated
//   bcd    out  [4*DIGITS-1:0] packed BCD, digit 0 (ones) in bits [3:0]
//
// States:
//   state | meaning
//   IDLE  | waiting for start; bcd holds last result
//   SHIFT | shifting one bit per clock through the scratch digits
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state;
    logic [WIDTH-1:0]      sh;
    logic [4*DIGITS-1:0]   scr;
    logic [CW-1:0]         cnt;

    // Adjusted scratch digits. The top bit of the most significant digit is
    // shifted out and never kept, so only the bits that survive the shift
    // are computed.
    logic [4*DIGITS-2:0]   adj;
    logic [4*DIGITS-1:0]   scr_nxt;
    logic [WIDTH-1:0]      sh_nxt;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_adj
            if (k < DIGITS - 1) begin : g_full
                assign adj[4*k +: 4] = (scr[4*k +: 4] >= 4'd5) ?
                                       scr[4*k +: 4] + 4'd3 : scr[4*k +: 4];
            end else begin : g_top
                // Low three bits of a 4-bit +3 equal a 3-bit +3 of the low bits.
                assign adj[4*k +: 3] = (scr[4*k +: 4] >= 4'd5) ?
                                       scr[4*k +: 3] + 3'd3 : scr[4*k +: 3];
            end
        end
    endgenerate

    // {scratch, shift register} shifted left by one as a single vector.
    assign scr_nxt = {adj, sh[WIDTH-1]};
    assign sh_nxt  = sh << 1;

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= IDLE;
            sh    <= '0;
            scr   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh    <= bin;
                        scr   <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh  <= sh_nxt;
                    scr <= scr_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd   <= scr_nxt;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
